// File: rtl/prefetch_stage_pkg.sv
`default_nettype none
// Front-end types shared by prefetch and fetch: slot descriptors, the exception record and the prefetch FSM states.
package prefetch_stage_pkg;

  typedef logic [31:0] virt_t;

  localparam logic [4:0] EXCCODE_ADEL = 5'h04;

  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
    virt_t      badvaddr;
    virt_t      epc;
  } exception_t;

  typedef struct packed {
    logic       valid;
    virt_t      pc;
    exception_t exception;
  } prefetch_to_fetch_bus_t;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_RUN     = 2'd1,
    PF_EX_HOLD = 2'd2
  } pf_state_e;

  // Base address of the 8-byte instruction pair that contains pc.
  function automatic virt_t pair_base(input virt_t pc);
    return {pc[31:3], 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// Next fetch-PC and next-state priority mux for the prefetch stage (reset is applied by the register owner).
module pc_next_sel
  import prefetch_stage_pkg::*;
(
  input  pf_state_e state,
  input  virt_t     pc,
  input  logic      flush,
  input  virt_t     flush_target,
  input  logic      bpu_redirect,
  input  virt_t     bpu_target,
  input  logic      accept,
  input  logic      exc_pkt,
  output virt_t     next_pc,
  output pf_state_e next_state
);

  always_comb begin
    next_pc    = pc;
    next_state = state;
    if (flush) begin
      next_pc    = flush_target;
      next_state = PF_RUN;
    end else if (state != PF_EX_HOLD) begin
      // Once an AdEL packet has gone out only a flush may move the PC again.
      next_state = exc_pkt ? PF_EX_HOLD : PF_RUN;
      if (bpu_redirect) begin
        next_pc = bpu_target;
      end else if (accept) begin
        next_pc = pair_base(pc) + 32'd8;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/prefetch_stage.sv
`default_nettype none
// Front-end stage 0: owns the fetch PC, issues pair-aligned ICache requests and
// hands two slot descriptors per accepted request (or one AdEL packet) to fetch.
module prefetch_stage
  import prefetch_stage_pkg::*;
#(
  parameter virt_t      RESET_PC = 32'hBFC0_0000,
  parameter logic [4:0] EXC_ADEL = EXCCODE_ADEL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [31:0]            flush_target,
  input  logic                   bpu_redirect,
  input  logic [31:0]            bpu_target,
  input  logic                   fs_allowin,
  output logic                   pfs_to_valid,
  output prefetch_to_fetch_bus_t prefetch_to_fetch_bus1,
  output prefetch_to_fetch_bus_t prefetch_to_fetch_bus2,
  output logic                   icache_req,
  output logic [31:0]            icache_addr,
  input  logic                   icache_addr_ok
);

  pf_state_e state;
  pf_state_e next_state;
  virt_t     pc;
  virt_t     next_pc;
  logic      misalign;
  logic      running;
  logic      accept;
  logic      exc_pkt;

  assign misalign = pc[1:0] != 2'b00;
  assign running  = state == PF_RUN;

  // Requests are only raised with queue space, so an accepted pair is always enqueued.
  assign icache_req   = running && !misalign && fs_allowin && !flush;
  assign exc_pkt      = running && misalign && fs_allowin && !flush;
  assign accept       = icache_req && icache_addr_ok;
  assign pfs_to_valid = accept || exc_pkt;
  assign icache_addr  = pair_base(pc);

  always_comb begin
    prefetch_to_fetch_bus1     = '0;
    prefetch_to_fetch_bus2     = '0;
    prefetch_to_fetch_bus1.pc  = icache_addr;
    prefetch_to_fetch_bus2.pc  = icache_addr + 32'd4;
    if (exc_pkt) begin
      prefetch_to_fetch_bus1.valid              = 1'b1;
      prefetch_to_fetch_bus2.valid              = 1'b1;
      prefetch_to_fetch_bus1.exception.ex       = 1'b1;
      prefetch_to_fetch_bus1.exception.exccode  = EXC_ADEL;
      prefetch_to_fetch_bus1.exception.badvaddr = pc;
      prefetch_to_fetch_bus1.exception.epc      = pc;
      prefetch_to_fetch_bus2.exception          = prefetch_to_fetch_bus1.exception;
    end else if (accept) begin
      // A PC pointing at the upper word skips the lower slot of the pair.
      prefetch_to_fetch_bus1.valid = !pc[2];
      prefetch_to_fetch_bus2.valid = 1'b1;
    end
  end

  pc_next_sel u_pc_next_sel (
    .state        (state),
    .pc           (pc),
    .flush        (flush),
    .flush_target (flush_target),
    .bpu_redirect (bpu_redirect),
    .bpu_target   (bpu_target),
    .accept       (accept),
    .exc_pkt      (exc_pkt),
    .next_pc      (next_pc),
    .next_state   (next_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= PF_IDLE;
    end else begin
      pc    <= next_pc;
      state <= next_state;
    end
  end

endmodule
`default_nettype wire

// File: doc/prefetch_stage.md
Name: prefetch_stage

Overview:
- Front-end stage 0, directly upstream of the fetch stage.
- Owns the architectural fetch PC and issues 8-byte-aligned instruction-pair requests to the ICache.
- Delivers two slot descriptors per accepted request (pc, valid, exception) to the fetch queue.
- Applies redirects from pipeline flush and from the BPU, and turns a misaligned PC into an AdEL packet that never reaches the ICache.

Parameters:
- RESET_PC, 32'hBFC0_0000, fetch PC loaded on reset.
- EXC_ADEL, 5'h04, exccode used for instruction-address-error packets.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (exception/eret/mispredict); highest priority
- flush_target  in  32  PC to resume at after flush
- bpu_redirect  in  1  BPU predicted-taken redirect
- bpu_target  in  32  redirect PC from BPU
- fs_allowin  in  1  fetch queue can accept a pair this cycle
- pfs_to_valid  out  1  pair presented to fetch this cycle
- prefetch_to_fetch_bus1  out  prefetch_to_fetch_bus_t  slot for word at {pc[31:3],3'b000}
- prefetch_to_fetch_bus2  out  prefetch_to_fetch_bus_t  slot for word at {pc[31:3],3'b100}
- icache_req  out  1  ICache request valid
- icache_addr  out  32  request address, always {pc[31:3],3'b000}
- icache_addr_ok  in  1  ICache accepted request this cycle

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- State machine, encoding in package:
  - PF_IDLE: reset state, 1 cycle → PF_RUN.
  - PF_RUN: normal fetching.
  - PF_EX_HOLD: exception packet sent; no requests until flush.
- Reset values:
  - pc=RESET_PC, state=PF_IDLE.
  - icache_req=0, pfs_to_valid=0, both bus valid=0, exception='0.
- Define misalign = pc[1:0]!=0.
- In PF_RUN:
  - icache_req = !misalign && fs_allowin && !flush.
  - Request is not asserted while fs_allowin=0, so no ICache request is ever accepted without queue space.
- Normal acceptance:
  - Accept = icache_req && icache_addr_ok. On accept, pfs_to_valid=1 in the same cycle; fetch enqueues the pair that cycle.
  - bus1.valid = !pc[2]; bus2.valid = 1; bus1.pc = {pc[31:3],3'b000}; bus2.pc = bus1.pc+4; exception='0.
- Exception packet:
  - Condition: PF_RUN, misalign, fs_allowin, !flush.
  - Drive pfs_to_valid=1, icache_req=0.
  - Both slots valid=1, exception.ex=1, exccode=EXC_ADEL, badvaddr=pc, epc=pc.
  - Next state PF_EX_HOLD.
- Next-PC priority, evaluated every cycle:
  1. reset → RESET_PC.
  2. flush → flush_target; state→PF_RUN; any same-cycle accept is dropped (pfs_to_valid forced 0).
  3. bpu_redirect → bpu_target. The current-cycle accept, if any, is still delivered; fetch resolves delay-slot validity.
  4. accept → {pc[31:3],3'b000}+32'd8. Arithmetic is 32-bit wrapping; 0xFFFF_FFF8 → 0x0000_0000.
  5. Otherwise hold.
- Redirect arriving while stalled (fs_allowin=0 or addr_ok=0) overwrites pc immediately. The pending un-accepted request is abandoned and the new address is presented next cycle.
- Redirect to a misaligned target yields an AdEL packet on the next issue opportunity.
- In PF_EX_HOLD:
  - Ignores bpu_redirect; outputs idle.
  - Only flush or reset leaves the state.
- Reset and flush in the same cycle: reset wins.
- icache_addr is stable while icache_req=1 and not accepted, unless a redirect occurs.
- Latency: redirect applied in cycle N → request at the new PC visible in cycle N+1.

Decomposition:
- cpu package, shared with fetch: prefetch_to_fetch_bus_t (valid, pc, exception_t), exception_t, virt_t, prefetch state enum, EXC_ADEL constant.
- One sub-module, pc_next_sel: combinational priority mux producing next pc and the next-state select.
- FSM and output drive stay in prefetch_stage.

Test Plan:
- Reset release, fs_allowin=1, addr_ok=1:
  - Cycle 1: icache_req=0.
  - Then pairs at 0xBFC00000, 0xBFC00008, 0xBFC00010, with bus1/bus2 valid=1/1.
- bpu_redirect to 0x80001004 together with the accept of 0xBFC00008:
  - Pair 0xBFC00008 is delivered.
  - Next request addr 0x80001000 with bus1.valid=0, bus2.pc=0x80001004.
- addr_ok=0 for 3 cycles with fs_allowin=1:
  - icache_addr held at 0xBFC00010, pfs_to_valid=0.
  - 4th cycle accept, pc→0xBFC00018.
- flush(target 0x80000180) in the same cycle as accept of 0xBFC00020:
  - pfs_to_valid=0 that cycle.
  - Next request 0x80000180.
- bpu_target 0x80002002:
  - pfs_to_valid=1, icache_req=0, both ex=1, exccode=0x04, badvaddr=0x80002002.
  - Then idle under further bpu_redirect until flush to 0x80000180 resumes.
- fs_allowin=0 for 5 cycles: icache_req=0, pc held; reset asserted mid-stall → pc=0xBFC00000, state PF_IDLE.
